// File: rtl/mux_rr.sv
// mux_rr: N-channel registered multiplexer; picks one valid input stream per cycle.
// Latency: one cycle from an accepted input beat to out_valid.
// Backpressure: in_ready stays low while the output register is full and out_ready is low.
//
// Build option: define MUX_RR_EN for round-robin arbitration; otherwise the
// lowest-index valid channel wins. Manual select (man_en/man_sel) is the same
// in both builds.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    per-channel handshake (CHANNELS bits each)
//   in_data              channel i in bits [i*WIDTH +: WIDTH]
//   man_en, man_sel      forced channel select
//   out_valid/out_ready  output handshake
//   out_data, out_chan   registered beat and its source channel
module mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      man_en,
  input  logic [SELW-1:0]           man_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan
);

  // live_q holds in_ready low until the first clock edge after reset release.
  logic                live_q, live_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_chan_q, out_chan_d;

  logic                load;
  logic                accept;
  logic                win_found;
  logic [SELW-1:0]     win_idx;
  logic [CHANNELS-1:0] grant;
  logic [WIDTH-1:0]    win_dat;

`ifdef MUX_RR_EN
  logic [SELW-1:0]     ptr_q, ptr_d;
`endif

  // Winner selection: forced channel, or a scan over the valid vector.
  always_comb begin : arbitrate
    logic [SELW-1:0] idx;
    int              sum;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    sum       = 0;
    if (man_en) begin
      // Out-of-range selects (non power-of-two CHANNELS) produce no grant.
      if ((int'(man_sel) < CHANNELS) && in_valid[man_sel]) begin
        win_found = 1'b1;
        win_idx   = man_sel;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
`ifdef MUX_RR_EN
        // Scan upward from ptr, wrapping explicitly at CHANNELS.
        sum = int'(ptr_q) + i;
        if (sum >= CHANNELS) sum = sum - CHANNELS;
`else
        sum = i;
`endif
        idx = SELW'(sum);
        if (!win_found && in_valid[idx]) begin
          win_found = 1'b1;
          win_idx   = idx;
        end
      end
    end
  end

  // One-hot grant and the winner's data.
  always_comb begin
    grant   = '0;
    win_dat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (win_found && (win_idx == SELW'(i))) begin
        grant[i] = 1'b1;
        win_dat  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load     = ~out_valid_q | out_ready;
  assign in_ready = grant & {CHANNELS{load & live_q}};
  assign accept   = |in_ready;

  always_comb begin
    live_d      = 1'b1;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = win_dat;
      out_chan_d  = win_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef MUX_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (accept && !man_en) begin
      ptr_d = (win_idx == SELW'(CHANNELS - 1)) ? '0 : win_idx + SELW'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
`ifdef MUX_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      live_q      <= live_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
`ifdef MUX_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
